// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Entry fields are XLEN wide; DATA_LEN/ADDR_LEN on ifu_prefetch must match XLEN.
package ifu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0]      RESP_OKAY        = 3'b000;
  localparam logic [XLEN-1:0] RST_PC_DEFAULT   = 32'h8000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fifo_entry_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Fetch-side bundle: redirect, AXI-style AR/R channels and the IDU handshake.
// master = prefetch unit, slave = bus/IDU side.
interface ifu_prefetch_if #(
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32
);
  logic                jump_flag;
  logic [ADDR_LEN-1:0] jump_pc;
  logic                arvalid;
  logic                arready;
  logic [ADDR_LEN-1:0] araddr;
  logic [DATA_LEN-1:0] rdata;
  logic                rvalid;
  logic [2:0]          rresp;
  logic                rready;
  logic                inst_valid;
  logic                inst_ready;
  logic [DATA_LEN-1:0] inst_fetch;
  logic [ADDR_LEN-1:0] pc_now;
  logic                inst_fault;

  modport master (
    input  jump_flag, jump_pc, arready, rdata, rvalid, rresp, inst_ready,
    output arvalid, araddr, rready, inst_valid, inst_fetch, pc_now, inst_fault
  );

  modport slave (
    output jump_flag, jump_pc, arready, rdata, rvalid, rresp, inst_ready,
    input  arvalid, araddr, rready, inst_valid, inst_fetch, pc_now, inst_fault
  );
endinterface

// File: rtl/ifu_inst_fifo.sv
// In-order synchronous FIFO with flush and a registered head entry.
// The head register keeps its last value while the FIFO is empty.
module ifu_inst_fifo #(
  parameter int unsigned     Depth  = 4,
  parameter int unsigned     Width  = 65,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [$clog2(Depth):0] count_o,
  output logic [Width-1:0]       head_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d, remain;
  logic [Width-1:0] head_q, head_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & ((count_q != CntW'(Depth)) | do_pop) & ~flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    remain   = count_q - CntW'(do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = remain + CntW'(do_push);
      // Pushed entry becomes head directly when nothing older remains.
      if (count_d != '0) head_d = (remain == '0) ? push_data_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= RstVal;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: credit-limited sequential AR issue, in-order response buffering,
// flush/discard on redirect and fault tagging. IFU_PERF_CNT_EN adds performance counters.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned          DATA_LEN   = 32,
  parameter int unsigned          ADDR_LEN   = 32,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [ADDR_LEN-1:0]  RST_PC     = RST_PC_DEFAULT,
  parameter logic [DATA_LEN-1:0]  NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ifu_prefetch_if.master        bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_inst_cnt,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);
  localparam int unsigned    CntW     = cnt_w(FIFO_DEPTH);
  localparam logic [CntW:0]  DepthLim = (CntW + 1)'(FIFO_DEPTH);
  typedef logic [CntW-1:0] cnt_t;

  logic                arvalid_q, arvalid_d, fault_stall_q, fault_stall_d, stale_q, stale_d;
  logic [ADDR_LEN-1:0] araddr_q, araddr_d, fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  cnt_t                outst_q, outst_d, discard_q, discard_d, fifo_cnt, cnt_next;
  logic [CntW:0]       credit_sum;
  fifo_entry_t         push_entry, head;
  logic                ar_hs, r_beat, drop_disc, push, pop, inst_valid;

  assign ar_hs      = arvalid_q & bus.arready;
  assign r_beat     = bus.rvalid;
  assign drop_disc  = r_beat & (discard_q != '0);
  assign push       = r_beat & ~drop_disc & ~fault_stall_q & ~bus.jump_flag;
  assign inst_valid = (fifo_cnt != '0);
  assign pop        = inst_valid & bus.inst_ready & ~bus.jump_flag;

  assign push_entry.inst  = (bus.rresp == RESP_OKAY) ? bus.rdata : NOP_INST;
  assign push_entry.pc    = resp_pc_q;
  assign push_entry.fault = (bus.rresp != RESP_OKAY);

  ifu_inst_fifo #(
    .Depth  (FIFO_DEPTH),
    .Width  ($bits(fifo_entry_t)),
    .RstVal ({NOP_INST, RST_PC, 1'b0})
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (bus.jump_flag),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (fifo_cnt),
    .head_o      (head)
  );

  always_comb begin
    outst_d       = outst_q + cnt_t'(ar_hs) - cnt_t'(r_beat);
    cnt_next      = bus.jump_flag ? '0 : fifo_cnt + cnt_t'(push) - cnt_t'(pop);
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    fault_stall_d = fault_stall_q;
    stale_d       = stale_q;
    // A stale request (pre-redirect address) does not advance fetch_pc and is discarded.
    if (ar_hs) begin
      if (!stale_q) fetch_pc_d = fetch_pc_q + ADDR_LEN'(4);
      stale_d = 1'b0;
    end
    if (r_beat) begin
      if (drop_disc) begin
        discard_d = discard_q - cnt_t'(1);
      end else begin
        resp_pc_d = resp_pc_q + ADDR_LEN'(4);
        if (!fault_stall_q && bus.rresp != RESP_OKAY) fault_stall_d = 1'b1;
      end
    end
    if (ar_hs && stale_q) discard_d = discard_d + cnt_t'(1);
    if (bus.jump_flag) begin
      fetch_pc_d    = bus.jump_pc;
      resp_pc_d     = bus.jump_pc;
      fault_stall_d = 1'b0;
      discard_d     = outst_d;
      if (arvalid_q && !bus.arready) stale_d = 1'b1;
    end
    credit_sum = {1'b0, outst_d} + {1'b0, cnt_next};
    if (arvalid_q && !bus.arready) begin
      arvalid_d = 1'b1;
      araddr_d  = araddr_q;
    end else begin
      arvalid_d = ~fault_stall_d & (credit_sum < DepthLim);
      araddr_d  = fetch_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arvalid_q     <= 1'b0;
      araddr_q      <= RST_PC;
      fetch_pc_q    <= RST_PC;
      resp_pc_q     <= RST_PC;
      outst_q       <= '0;
      discard_q     <= '0;
      fault_stall_q <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      arvalid_q     <= arvalid_d;
      araddr_q      <= araddr_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outst_q       <= outst_d;
      discard_q     <= discard_d;
      fault_stall_q <= fault_stall_d;
      stale_q       <= stale_d;
    end
  end

  assign bus.arvalid    = arvalid_q;
  assign bus.araddr     = araddr_q;
  assign bus.rready     = 1'b1;
  assign bus.inst_valid = inst_valid;
  assign bus.inst_fetch = inst_valid ? head.inst : NOP_INST;
  assign bus.pc_now     = head.pc;
  assign bus.inst_fault = inst_valid & head.fault;

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_inst_cnt  <= '0;
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (inst_valid && bus.inst_ready) perf_inst_cnt  <= perf_inst_cnt + 32'd1;
      if (bus.jump_flag)                perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (bus.inst_ready && !inst_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: expected ARs and instructions are queued by the
// directed tests; a responder and a monitor pop and compare as the DUT presents them.
module tb_ifu_prefetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_prefetch_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_inst_cnt, perf_flush_cnt, perf_stall_cnt;
`endif

  ifu_prefetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_inst_cnt  (perf_inst_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_ar[$];
  logic [31:0] pend[$];
  int          total = 0;
  int          bad = 0;
  int          ar_seen = 0;
  int          budget = 0;
  int          streak = 0;
  int          max_streak = 0;
  logic [31:0] err_addr = 32'hffff_fff0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Responder: one beat per cycle from the pending queue while budget allows.
  initial begin
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    bus.rresp  = 3'b000;
    forever begin
      logic [31:0] a;
      @(negedge clk);
      #1;
      bus.rvalid = 1'b0;
      if (!rst_n) begin
        pend.delete();
      end else begin
        if (budget > 0 && pend.size() > 0) begin
          a = pend.pop_front();
          bus.rvalid = 1'b1;
          bus.rdata  = a;
          bus.rresp  = (a == err_addr) ? 3'b010 : 3'b000;
          budget--;
        end
        if (bus.arvalid && bus.arready) begin
          ar_seen++;
          pend.push_back(bus.araddr);
          if (exp_ar.size() == 0) check("ar_extra", bus.araddr, 32'hxxxx_xxxx);
          else check("araddr", bus.araddr, exp_ar.pop_front());
        end
      end
    end
  end

  // Monitor: compare every dequeued head against the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.inst_valid && bus.inst_ready && !bus.jump_flag) begin
        streak++;
        if (streak > max_streak) max_streak = streak;
        if (exp_q.size() == 0) begin
          check("inst_extra", bus.pc_now, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("pc_now", bus.pc_now, e.pc);
          check("inst_fetch", bus.inst_fetch, e.inst);
          check("inst_fault", {31'd0, bus.inst_fault}, {31'd0, e.fault});
        end
      end else begin
        streak = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.arready    = 1'b0;
    bus.inst_ready = 1'b0;
    bus.jump_flag  = 1'b0;
    bus.jump_pc    = '0;
    budget         = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    cyc(3);
  endtask

  task automatic wait_ar(input int target);
    int t = 0;
    while (ar_seen < target && t < 300) begin
      cyc(1);
      t++;
    end
    check("ar_count", ar_seen, target);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      cyc(1);
      t++;
    end
    cyc(4);
    check("exp_left", exp_q.size(), 0);
    check("exp_ar_left", exp_ar.size(), 0);
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_ar.push_back(base + 32'(4 * i));
      exp_q.push_back('{pc: base + 32'(4 * i), inst: base + 32'(4 * i), fault: 1'b0});
    end
  endtask

  task automatic jump(input logic [31:0] pc);
    bus.jump_flag = 1'b1;
    bus.jump_pc   = pc;
    cyc(1);
    bus.jump_flag = 1'b0;
  endtask

  task automatic check_reset_outs();
    check("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("rst_araddr", bus.araddr, 32'h8000_0000);
    check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_inst_fetch", bus.inst_fetch, 32'h0000_0013);
    check("rst_pc_now", bus.pc_now, 32'h8000_0000);
    check("rst_inst_fault", {31'd0, bus.inst_fault}, 32'd0);
    check("rst_rready", {31'd0, bus.rready}, 32'd1);
  endtask

  initial begin
    int base;
    idle_inputs();
    cyc(2);
    check_reset_outs();

    // Streaming fetch, one instruction per cycle.
    do_reset();
    base = ar_seen;
    push_seq(32'h8000_0000, 8);
    budget = 1000;
    bus.inst_ready = 1'b1;
    bus.arready = 1'b1;
    rst_n = 1'b1;
    wait_ar(base + 8);
    bus.arready = 1'b0;
    drain();
    check("max_streak", max_streak, 8);

    // Credit limit with a stalled IDU.
    do_reset();
    base = ar_seen;
    push_seq(32'h8000_0000, 5);
    budget = 1000;
    bus.arready = 1'b1;
    rst_n = 1'b1;
    cyc(12);
    check("credit_ars", ar_seen - base, 4);
    check("credit_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("credit_valid", {31'd0, bus.inst_valid}, 32'd1);
    bus.inst_ready = 1'b1;
    cyc(1);
    bus.inst_ready = 1'b0;
    cyc(8);
    check("pulse_ars", ar_seen - base, 5);
    check("pulse_arvalid", {31'd0, bus.arvalid}, 32'd0);
    bus.arready = 1'b0;
    bus.inst_ready = 1'b1;
    drain();

    // Flush with 3 outstanding and 1 buffered.
    do_reset();
    base = ar_seen;
    for (int i = 0; i < 4; i++) exp_ar.push_back(32'h8000_0000 + 32'(4 * i));
    push_seq(32'h8000_1000, 8);
    bus.arready = 1'b1;
    rst_n = 1'b1;
    wait_ar(base + 4);
    bus.arready = 1'b0;
    cyc(2);
    budget = 1;
    cyc(3);
    check("pre_flush_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("pre_flush_inst", bus.inst_fetch, 32'h8000_0000);
    jump(32'h8000_1000);
    check("flush_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("flush_inst", bus.inst_fetch, 32'h0000_0013);
    check("flush_arvalid", {31'd0, bus.arvalid}, 32'd1);
    check("flush_araddr", bus.araddr, 32'h8000_1000);
    budget = 3;
    cyc(6);
    check("dropped_valid", {31'd0, bus.inst_valid}, 32'd0);
    bus.inst_ready = 1'b1;
    bus.arready = 1'b1;
    budget = 1000;
    wait_ar(base + 12);
    bus.arready = 1'b0;
    drain();

    // Error response stalls issue until redirect.
    do_reset();
    base = ar_seen;
    err_addr = 32'h8000_0008;
    for (int i = 0; i < 4; i++) exp_ar.push_back(32'h8000_0000 + 32'(4 * i));
    exp_q.push_back('{pc: 32'h8000_0000, inst: 32'h8000_0000, fault: 1'b0});
    exp_q.push_back('{pc: 32'h8000_0004, inst: 32'h8000_0004, fault: 1'b0});
    exp_q.push_back('{pc: 32'h8000_0008, inst: 32'h0000_0013, fault: 1'b1});
    push_seq(32'h8000_0100, 4);
    budget = 1000;
    bus.inst_ready = 1'b1;
    bus.arready = 1'b1;
    rst_n = 1'b1;
    cyc(12);
    check("fault_ars", ar_seen - base, 4);
    check("fault_arvalid", {31'd0, bus.arvalid}, 32'd0);
    jump(32'h8000_0100);
    wait_ar(base + 8);
    bus.arready = 1'b0;
    drain();
    err_addr = 32'hffff_fff0;

    // Held AR across back-to-back redirects.
    do_reset();
    base = ar_seen;
    exp_ar.push_back(32'h8000_0000);
    push_seq(32'h8000_3000, 4);
    budget = 1000;
    bus.inst_ready = 1'b1;
    rst_n = 1'b1;
    cyc(3);
    check("hold_arvalid", {31'd0, bus.arvalid}, 32'd1);
    check("hold_araddr", bus.araddr, 32'h8000_0000);
    bus.jump_flag = 1'b1;
    bus.jump_pc = 32'h8000_2000;
    cyc(1);
    jump(32'h8000_3000);
    check("jhold_arvalid", {31'd0, bus.arvalid}, 32'd1);
    check("jhold_araddr", bus.araddr, 32'h8000_0000);
    cyc(2);
    check("jhold_araddr2", bus.araddr, 32'h8000_0000);
    bus.arready = 1'b1;
    wait_ar(base + 5);
    bus.arready = 1'b0;
    drain();

    // Reset with requests outstanding.
    do_reset();
    base = ar_seen;
    exp_ar.push_back(32'h8000_0000);
    exp_ar.push_back(32'h8000_0004);
    bus.inst_ready = 1'b1;
    bus.arready = 1'b1;
    rst_n = 1'b1;
    wait_ar(base + 2);
    bus.arready = 1'b0;
    cyc(1);
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    cyc(2);
    push_seq(32'h8000_0000, 2);
    budget = 1000;
    bus.arready = 1'b1;
    rst_n = 1'b1;
    wait_ar(base + 4);
    bus.arready = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
